// File: rtl/control_pipe.sv
// control_pipe: RV32I control decoder with ID/EX control register, stall/flush and mul/div busy FSM.
// Define CONTROL_MULDIV_EN to decode M-extension ops and enable the multi-cycle busy FSM.
module control_pipe #(
  parameter int ALUCTRL_W     = 5,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          InstrD,
  input  logic                 ValidD,
  input  logic                 StallD,
  input  logic                 FlushE,
  output logic [2:0]           ImmSrcD,
  output logic                 RegWriteE,
  output logic                 MemWriteE,
  output logic                 BranchE,
  output logic                 JumpE,
  output logic                 JalrE,
  output logic                 ALUSrcE,
  output logic                 ALUASrcE,
  output logic [1:0]           ResultSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 IllegalE,
  output logic                 ValidE,
  output logic                 StallOutD
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_SLT   = 5'd5;
  localparam logic [4:0] ALU_SLTU  = 5'd6;
  localparam logic [4:0] ALU_SLL   = 5'd7;
  localparam logic [4:0] ALU_SRL   = 5'd8;
  localparam logic [4:0] ALU_SRA   = 5'd9;
  localparam logic [4:0] ALU_PASSB = 5'd10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       alu_src;
    logic       alu_a_src;
    logic [1:0] result_src;
    logic [4:0] alu_ctrl;
    logic       illegal;
    logic       valid;
  } ctrl_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = InstrD[6:0];
  assign funct3        = InstrD[14:12];
  assign funct7        = InstrD[31:25];
  assign unused_fields = ^{InstrD[24:15], InstrD[11:7]};

  ctrl_t      dec;
  ctrl_t      dec_word;
  logic [2:0] imm_src;
  logic [4:0] alu_base;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    dec      = '0;
    imm_src  = 3'b000;
    alu_base = ALU_ADD;

    case (funct3)
      3'b000:  alu_base = (opcode == OP_RTYPE && funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_base = ALU_SLL;
      3'b010:  alu_base = ALU_SLT;
      3'b011:  alu_base = ALU_SLTU;
      3'b100:  alu_base = ALU_XOR;
      3'b101:  alu_base = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_base = ALU_OR;
      default: alu_base = ALU_AND;
    endcase

    case (opcode)
      OP_LOAD: begin
        dec.result_src = 2'b01;
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
      end
      OP_STORE: begin
        imm_src       = 3'b001;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_RTYPE: begin
        if (funct7 == 7'b0000001) begin
`ifdef CONTROL_MULDIV_EN
          dec.reg_write = 1'b1;
          dec.alu_ctrl  = {2'b10, funct3};
`else
          dec.illegal   = 1'b1;
`endif
        end else begin
          dec.reg_write = 1'b1;
          dec.alu_ctrl  = alu_base;
        end
      end
      OP_IALU: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = alu_base;
      end
      OP_BRANCH: begin
        imm_src      = 3'b010;
        dec.branch   = 1'b1;
        dec.alu_ctrl = ALU_SUB;
      end
      OP_JAL: begin
        imm_src        = 3'b011;
        dec.jump       = 1'b1;
        dec.result_src = 2'b10;
        dec.reg_write  = 1'b1;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          dec.jump       = 1'b1;
          dec.jalr       = 1'b1;
          dec.alu_src    = 1'b1;
          dec.result_src = 2'b10;
          dec.reg_write  = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_LUI: begin
        imm_src       = 3'b100;
        dec.alu_ctrl  = ALU_PASSB;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        imm_src       = 3'b100;
        dec.alu_a_src = 1'b1;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.valid = 1'b1;
  end

  // An empty ID slot becomes a bubble, which also keeps IllegalE low for it.
  assign dec_word = ValidD ? dec : '0;
  assign ImmSrcD  = imm_src;

  logic  busy;
  ctrl_t ctrl_d, ctrl_q;

  always_comb begin
    ctrl_d = ctrl_q;
    if (FlushE)      ctrl_d = '0;
    else if (busy)   ctrl_d = ctrl_q;
    else if (StallD) ctrl_d = '0;
    else             ctrl_d = dec_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) ctrl_q <= '0;
    else        ctrl_q <= ctrl_d;
  end

`ifdef CONTROL_MULDIV_EN
  localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             load_muldiv;

  assign load_muldiv = !FlushE && !StallD && dec_word.valid && dec_word.alu_ctrl[4];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (load_muldiv && MULDIV_CYCLES > 1) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (FlushE) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == BUSY);
  assign StallOutD = busy;
`else
  assign busy      = 1'b0;
  assign StallOutD = 1'b0;
`endif

  assign RegWriteE   = ctrl_q.reg_write;
  assign MemWriteE   = ctrl_q.mem_write;
  assign BranchE     = ctrl_q.branch;
  assign JumpE       = ctrl_q.jump;
  assign JalrE       = ctrl_q.jalr;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign ALUASrcE    = ctrl_q.alu_a_src;
  assign ResultSrcE  = ctrl_q.result_src;
  assign ALUControlE = ALUCTRL_W'(ctrl_q.alu_ctrl);
  assign IllegalE    = ctrl_q.illegal;
  assign ValidE      = ctrl_q.valid;

endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: table vectors, hand-written multi-cycle sequences and random stimulus
// checked against a rule-level reference model of control_pipe.
module tb_control_pipe;

  localparam int ALUCTRL_W     = 5;
  localparam int MULDIV_CYCLES = 4;

`ifdef CONTROL_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  localparam logic [31:0] I_ADDI = 32'h00A28293;
  localparam logic [31:0] I_LUI  = 32'h000002B7;
  localparam logic [31:0] I_DIV  = 32'h02C5C533;

  typedef struct packed {
    logic       rw, mw, br, jp, jl, as, aa;
    logic [1:0] rs;
    logic [7:0] alu;
    logic       ill;
    logic       valid;
  } eword_t;

  typedef struct {
    logic [31:0] instr;
    logic        v, st, fl;
    logic [2:0]  imm;
    eword_t      e;
  } vec_t;

  logic                 clk;
  logic                 rst_n;
  logic [31:0]          InstrD;
  logic                 ValidD, StallD, FlushE;
  logic [2:0]           ImmSrcD;
  logic                 RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, ALUASrcE;
  logic [1:0]           ResultSrcE;
  logic [ALUCTRL_W-1:0] ALUControlE;
  logic                 IllegalE, ValidE, StallOutD;

  control_pipe #(.ALUCTRL_W(ALUCTRL_W), .MULDIV_CYCLES(MULDIV_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .ValidD(ValidD), .StallD(StallD),
    .FlushE(FlushE), .ImmSrcD(ImmSrcD), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .ALUSrcE(ALUSrcE),
    .ALUASrcE(ALUASrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .IllegalE(IllegalE), .ValidE(ValidE), .StallOutD(StallOutD)
  );

  eword_t act_e;
  assign act_e = {RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, ALUASrcE,
                  ResultSrcE, 8'(ALUControlE), IllegalE, ValidE};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_cmp  = 0;
  int     n_fail = 0;
  eword_t exp_e  = '0;
  int     busy_left = 0;
  vec_t   vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic eword_t mk(input bit rw, mw, br, jp, jl, as, aa,
                                input bit [1:0] rs, input int alu, input bit ill);
    eword_t e;
    e = '{rw:rw, mw:mw, br:br, jp:jp, jl:jl, as:as, aa:aa, rs:rs,
          alu:8'(alu), ill:ill, valid:1'b1};
    return e;
  endfunction

  // Reference decode: control word from the opcode rules of the RV32I(+M) table.
  function automatic eword_t model_e(input logic [31:0] ins, input logic v);
    int         alu_by_f3 [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
    int         alu;
    logic [6:0] op, f7;
    logic [2:0] f3;
    eword_t     ill_word;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    ill_word = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    if (!v) return '0;
    alu = alu_by_f3[f3];
    if (f3 == 3'd5 && f7[5]) alu = 9;
    if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) alu = 1;
    case (op)
      7'h03: return mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      7'h23: return mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
      7'h13: return mk(1, 0, 0, 0, 0, 1, 0, 0, alu, 0);
      7'h33: begin
        if (f7 == 7'h01) return MD_EN ? mk(1, 0, 0, 0, 0, 0, 0, 0, 16 + int'(f3), 0) : ill_word;
        return mk(1, 0, 0, 0, 0, 0, 0, 0, alu, 0);
      end
      7'h63: return mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
      7'h6F: return mk(1, 0, 0, 1, 0, 0, 0, 2, 0, 0);
      7'h67: return (f3 == 3'd0) ? mk(1, 0, 0, 1, 1, 1, 0, 2, 0, 0) : ill_word;
      7'h37: return mk(1, 0, 0, 0, 0, 1, 0, 0, 10, 0);
      7'h17: return mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      default: return ill_word;
    endcase
  endfunction

  function automatic logic [2:0] model_imm(input logic [31:0] ins);
    case (ins[6:0])
      7'h23:        return 3'd1;
      7'h63:        return 3'd2;
      7'h6F:        return 3'd3;
      7'h37, 7'h17: return 3'd4;
      default:      return 3'd0;
    endcase
  endfunction

  // One clock edge of the ID/EX boundary: flush, then busy hold, then stall, then load.
  task automatic model_step(input logic [31:0] ins, input logic v, input logic st, input logic fl);
    if (fl) begin
      exp_e = '0;
      busy_left = 0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (st) begin
      exp_e = '0;
    end else begin
      exp_e = model_e(ins, v);
      if (exp_e.valid && exp_e.alu >= 16 && MULDIV_CYCLES > 1) busy_left = MULDIV_CYCLES - 1;
    end
  endtask

  task automatic cycle(input logic [31:0] ins, input logic v, input logic st, input logic fl,
                       input string tag);
    @(negedge clk);
    InstrD = ins; ValidD = v; StallD = st; FlushE = fl;
    #1;
    check({tag, " imm_src"}, 32'(ImmSrcD), 32'(model_imm(ins)));
    check({tag, " stall_out"}, 32'(StallOutD), 32'(busy_left > 0));
    @(posedge clk);
    model_step(ins, v, st, fl);
    #1;
    check({tag, " e_word"}, 32'(act_e), 32'(exp_e));
  endtask

  task automatic apply_vec(input vec_t t, input int idx);
    @(negedge clk);
    InstrD = t.instr; ValidD = t.v; StallD = t.st; FlushE = t.fl;
    #1;
    check($sformatf("vec%0d imm_src", idx), 32'(ImmSrcD), 32'(t.imm));
    @(posedge clk);
    model_step(t.instr, t.v, t.st, t.fl);
    #1;
    check($sformatf("vec%0d e_word", idx), 32'(act_e), 32'(t.e));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    logic [31:0] ins;
    int          k;
    ins = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) ins[6:0] = ops[k];
    else if (k == 9) ins[6:0] = 7'h33;
    if (ins[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0:       ins[31:25] = 7'h00;
        1:       ins[31:25] = 7'h20;
        2:       ins[31:25] = 7'h01;
        default: ;
      endcase
    end
    if (ins[6:0] == 7'h67 && $urandom_range(0, 3) != 0) ins[14:12] = 3'd0;
    return ins;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int n_busy;
    logic [31:0] ins;

    rst_n = 1'b0; InstrD = I_LUI; ValidD = 1'b1; StallD = 1'b0; FlushE = 1'b0;
    #3;
    check("reset e_word", 32'(act_e), 32'h0);
    check("reset stall_out", 32'(StallOutD), 32'h0);
    check("reset imm follows instr", 32'(ImmSrcD), 32'h4);
    @(posedge clk); #1;
    check("reset holds through edge", 32'(act_e), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{32'h00A28293, 1, 0, 0, 3'd0, mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0)});  // addi
    vecs.push_back('{32'h000002B7, 1, 0, 0, 3'd4, mk(1, 0, 0, 0, 0, 1, 0, 0, 10, 0)}); // lui
    vecs.push_back('{32'h0000007F, 1, 0, 0, 3'd0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)});  // illegal
    vecs.push_back('{32'h00552023, 1, 1, 0, 3'd1, eword_t'(0)});                       // sw, stalled
    vecs.push_back('{32'h00552023, 1, 0, 0, 3'd1, mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0)});  // sw
    vecs.push_back('{32'h00A28293, 1, 1, 1, 3'd0, eword_t'(0)});                       // stall+flush
    vecs.push_back('{32'h40B50533, 1, 0, 0, 3'd0, mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0)});  // sub
    vecs.push_back('{32'h40B55533, 1, 0, 0, 3'd0, mk(1, 0, 0, 0, 0, 0, 0, 0, 9, 0)});  // sra
    vecs.push_back('{32'h4030D093, 1, 0, 0, 3'd0, mk(1, 0, 0, 0, 0, 1, 0, 0, 9, 0)});  // srai
    vecs.push_back('{32'h00B50463, 1, 0, 0, 3'd2, mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0)});  // beq
    vecs.push_back('{32'h008000EF, 1, 0, 0, 3'd3, mk(1, 0, 0, 1, 0, 0, 0, 2, 0, 0)});  // jal
    vecs.push_back('{32'h000080E7, 1, 0, 0, 3'd0, mk(1, 0, 0, 1, 1, 1, 0, 2, 0, 0)});  // jalr
    vecs.push_back('{32'h00000517, 1, 0, 0, 3'd4, mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0)});  // auipc
    vecs.push_back('{32'h0002A303, 1, 0, 0, 3'd0, mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0)});  // lw
    vecs.push_back('{32'h00A28293, 0, 0, 0, 3'd0, eword_t'(0)});                       // not valid
    vecs.push_back('{32'h00B57533, 1, 0, 0, 3'd0, mk(1, 0, 0, 0, 0, 0, 0, 0, 2, 0)});  // and
    vecs.push_back('{32'h000090E7, 1, 0, 0, 3'd0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1)});  // jalr f3!=0
    vecs.push_back('{32'h00A28293, 1, 0, 1, 3'd0, eword_t'(0)});                       // flush
    vecs.push_back('{32'h00B56533, 1, 0, 0, 3'd0, mk(1, 0, 0, 0, 0, 0, 0, 0, 3, 0)});  // or
    vecs.push_back('{32'h00309093, 1, 0, 0, 3'd0, mk(1, 0, 0, 0, 0, 1, 0, 0, 7, 0)});  // slli
    foreach (vecs[i]) apply_vec(vecs[i], i);

    // Multi-cycle divide: E frozen while the front end is stalled, then the next op loads.
    cycle(I_DIV, 1, 0, 0, "div_load");
`ifdef CONTROL_MULDIV_EN
    check("div alu code", 32'(ALUControlE), 32'd20);
    n_busy = 0;
    for (int i = 0; i < 10 && StallOutD; i++) begin
      cycle(I_ADDI, 1, 0, 0, "div_hold");
      check("div e held", 32'(ALUControlE), 32'd20);
      n_busy++;
    end
    check("div stall cycles", 32'(n_busy), 32'(MULDIV_CYCLES - 1));
    cycle(I_ADDI, 1, 0, 0, "after_div");
    check("after div alu", 32'(ALUControlE), 32'd0);
    check("after div reg_write", 32'(RegWriteE), 32'd1);
`else
    check("div illegal", 32'(IllegalE), 32'd1);
    check("div no stall", 32'(StallOutD), 32'd0);
    cycle(I_ADDI, 1, 0, 0, "after_div");
`endif

    // Flush arriving in the second busy cycle.
    cycle(I_DIV, 1, 0, 0, "fb_load");
    cycle(I_ADDI, 1, 0, 0, "fb_busy1");
    cycle(I_ADDI, 1, 0, 1, "fb_flush");
    check("flush clears valid", 32'(ValidE), 32'd0);
    check("flush clears stall", 32'(StallOutD), 32'd0);
    cycle(I_ADDI, 1, 0, 0, "fb_resume");

    // Asynchronous reset between edges, mid-busy when the divider is enabled.
    cycle(I_DIV, 1, 0, 0, "rst_load");
    #2 rst_n = 1'b0;
    #1;
    check("async reset e_word", 32'(act_e), 32'h0);
    check("async reset stall_out", 32'(StallOutD), 32'h0);
    exp_e = '0;
    busy_left = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(I_ADDI, 1, 0, 0, "post_rst");

    for (int i = 0; i < 400; i++) begin
      ins = rand_instr();
      cycle(ins, $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 11) == 0, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
